// File: rtl/dsm_seq_ctrl.sv
// rtl/dsm_seq_ctrl.sv - delta-sigma modulator sequencing controller (flush, ramp, lock, drain)
module dsm_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_word,
  input  logic [15:0] cfg_step,
  output logic        mod_en,
  output logic        mod_clr,
  output logic [15:0] mod_word,
  output logic        busy,
  output logic        settled
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RAMP  = 3'd2,
    S_LOCK  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Three flush cycles cover the two differentiator delays plus the output register.
  localparam logic [1:0] FLUSH_LAST = 2'd2;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] target_q, target_d;
  logic [15:0] step_q, step_d;
  logic [15:0] word_q, word_d;

  logic        cfg_accept;
  logic [16:0] up_sum;
  logic [16:0] dn_gap;
  logic [15:0] ramp_next;

  assign cfg_accept = cfg_valid & cfg_ready;
  assign mod_word   = word_q;

  // State and datapath registers; reset parks the modulator in IDLE at word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      target_q <= 16'd0;
      step_q   <= 16'd0;
      word_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      step_q   <= step_d;
      word_q   <= word_d;
    end
  end

  // One ramp step toward target, clamped so it never overshoots or wraps (17-bit compares).
  always_comb begin
    up_sum    = {1'b0, word_q} + {1'b0, step_q};
    dn_gap    = {1'b0, word_q} - {1'b0, target_q};
    ramp_next = word_q;
    if (target_q > word_q) begin
      if ((step_q == 16'd0) || (up_sum >= {1'b0, target_q})) begin
        ramp_next = target_q;
      end else begin
        ramp_next = up_sum[15:0];
      end
    end else if (target_q < word_q) begin
      if ((step_q == 16'd0) || ({1'b0, step_q} >= dn_gap)) begin
        ramp_next = target_q;
      end else begin
        ramp_next = word_q - step_q;
      end
    end
  end

  // Next-state logic; losing en outranks every other transition, including a cfg handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    step_d   = step_q;
    word_d   = word_q;
    case (state_q)
      S_IDLE: begin
        word_d = 16'd0;
        cnt_d  = 2'd0;
        if (cfg_accept) begin
          target_d = cfg_word;
          step_d   = cfg_step;
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        word_d = 16'd0;
        if (!en) begin
          cnt_d   = 2'd0;
          state_d = S_DRAIN;
        end else if (cnt_q == FLUSH_LAST) begin
          cnt_d   = 2'd0;
          state_d = S_RAMP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RAMP: begin
        if (!en) begin
          word_d  = 16'd0;
          state_d = S_DRAIN;
        end else begin
          word_d = ramp_next;
          if (ramp_next == target_q) begin
            state_d = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        if (!en) begin
          word_d  = 16'd0;
          state_d = S_DRAIN;
        end else if (cfg_accept) begin
          // Retarget from the current word without disturbing the noise shaper.
          target_d = cfg_word;
          step_d   = cfg_step;
          state_d  = S_RAMP;
        end
      end
      S_DRAIN: begin
        word_d  = 16'd0;
        state_d = S_IDLE;
      end
      default: begin
        word_d  = 16'd0;
        cnt_d   = 2'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from the state register.
  always_comb begin
    mod_clr   = (state_q == S_FLUSH) || (state_q == S_DRAIN);
    mod_en    = (state_q == S_RAMP) || (state_q == S_LOCK);
    settled   = (state_q == S_LOCK);
    busy      = (state_q == S_FLUSH) || (state_q == S_RAMP) || (state_q == S_DRAIN);
    cfg_ready = en && ((state_q == S_IDLE) || (state_q == S_LOCK));
  end

endmodule

// File: tb/tb_dsm_seq_ctrl.sv
// tb/tb_dsm_seq_ctrl.sv - directed self-checking bench for dsm_seq_ctrl
module tb_dsm_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_word;
  logic [15:0] cfg_step;
  logic        mod_en;
  logic        mod_clr;
  logic [15:0] mod_word;
  logic        busy;
  logic        settled;

  int n_chk  = 0;
  int n_fail = 0;

  dsm_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_word  (cfg_word),
    .cfg_step  (cfg_step),
    .mod_en    (mod_en),
    .mod_clr   (mod_clr),
    .mod_word  (mod_word),
    .busy      (busy),
    .settled   (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected packed as {mod_word, mod_en, mod_clr, settled, busy, cfg_ready}.
  task automatic chk(input string tag, input logic [15:0] w, input logic me, input logic mc,
                     input logic st, input logic bz, input logic rd);
    logic [20:0] obs;
    logic [20:0] exp_v;
    obs   = {mod_word, mod_en, mod_clr, settled, busy, cfg_ready};
    exp_v = {w, me, mc, st, bz, rd};
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed word=%h en/clr/set/busy/rdy=%b expected word=%h en/clr/set/busy/rdy=%b",
             tag, obs[20:5], obs[4:0], exp_v[20:5], exp_v[4:0]);
    end
  endtask

  task automatic offer(input logic [15:0] w, input logic [15:0] s);
    cfg_valid = 1'b1;
    cfg_word  = w;
    cfg_step  = s;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_word = 16'h0; cfg_step = 16'h0;
    #3;
    chk("reset_en0", 16'h0000, 0, 0, 0, 0, 0);
    en = 1'b1;
    #1;
    chk("reset_en1", 16'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;

    // Ramp 0 -> 0x0100 in 0x40 steps; cfg offered during flush/ramp must be ignored.
    offer(16'h0100, 16'h0040);
    tick(); chk("flush1", 16'h0000, 0, 1, 0, 1, 0);
    offer(16'h1234, 16'h0001);
    tick(); chk("flush2", 16'h0000, 0, 1, 0, 1, 0);
    tick(); chk("flush3", 16'h0000, 0, 1, 0, 1, 0);
    tick(); chk("ramp_entry", 16'h0000, 1, 0, 0, 1, 0);
    tick(); chk("ramp_40", 16'h0040, 1, 0, 0, 1, 0);
    tick(); chk("ramp_80", 16'h0080, 1, 0, 0, 1, 0);
    tick(); chk("ramp_c0", 16'h00C0, 1, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    tick(); chk("lock_100", 16'h0100, 1, 0, 1, 0, 1);
    tick(); chk("lock_hold", 16'h0100, 1, 0, 1, 0, 1);

    // Retarget from LOCK down to 0 without a flush.
    offer(16'h0000, 16'h0080);
    tick(); chk("relock_ramp", 16'h0100, 1, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    tick(); chk("down_80", 16'h0080, 1, 0, 0, 1, 0);
    tick(); chk("down_lock0", 16'h0000, 1, 0, 1, 0, 1);

    // Non-dividing step clamps at target.
    offer(16'h0050, 16'h0030);
    tick(); chk("nd_entry", 16'h0000, 1, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    tick(); chk("nd_30", 16'h0030, 1, 0, 0, 1, 0);
    tick(); chk("nd_clamp50", 16'h0050, 1, 0, 1, 0, 1);

    // Step 0 jumps straight to target.
    offer(16'h0010, 16'h0000);
    tick(); chk("jump_entry10", 16'h0050, 1, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    tick(); chk("jump_10", 16'h0010, 1, 0, 1, 0, 1);
    offer(16'hFFF0, 16'h0000);
    tick(); chk("jump_entryfff0", 16'h0010, 1, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    tick(); chk("jump_fff0", 16'hFFF0, 1, 0, 1, 0, 1);

    // Near the top of range: sum would wrap without the wide compare.
    offer(16'hFFFF, 16'h0100);
    tick(); chk("top_entry", 16'hFFF0, 1, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    tick(); chk("top_ffff", 16'hFFFF, 1, 0, 1, 0, 1);

    // Large downward step must not underflow.
    offer(16'h0005, 16'h8000);
    tick(); chk("big_dn_entry", 16'hFFFF, 1, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    tick(); chk("big_dn_7fff", 16'h7FFF, 1, 0, 0, 1, 0);
    tick(); chk("big_dn_lock5", 16'h0005, 1, 0, 1, 0, 1);

    // en dropped mid-ramp with cfg offered: drain wins, then idle.
    offer(16'h0105, 16'h0040);
    tick(); chk("drain_setup", 16'h0005, 1, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    tick(); chk("drain_45", 16'h0045, 1, 0, 0, 1, 0);
    en = 1'b0;
    offer(16'h2222, 16'h0001);
    #1;
    chk("drain_rdy0", 16'h0045, 1, 0, 0, 1, 0);
    tick(); chk("drain", 16'h0000, 0, 1, 0, 1, 0);
    tick(); chk("drain_idle", 16'h0000, 0, 0, 0, 0, 0);
    tick(); chk("idle_en0", 16'h0000, 0, 0, 0, 0, 0);
    cfg_valid = 1'b0;
    en = 1'b1;
    #1;
    chk("idle_en1", 16'h0000, 0, 0, 0, 0, 1);

    // Asynchronous reset mid-ramp.
    offer(16'h0200, 16'h0100);
    tick(); chk("rst_flush1", 16'h0000, 0, 1, 0, 1, 0);
    cfg_valid = 1'b0;
    tick();
    tick();
    tick(); chk("rst_ramp_entry", 16'h0000, 1, 0, 0, 1, 0);
    tick(); chk("rst_ramp_100", 16'h0100, 1, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 16'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    tick(); chk("post_rst_idle", 16'h0000, 0, 0, 0, 0, 1);
    offer(16'h0040, 16'h0040);
    tick(); chk("post_rst_flush", 16'h0000, 0, 1, 0, 1, 0);
    cfg_valid = 1'b0;
    tick();
    tick();
    tick(); chk("post_rst_ramp", 16'h0000, 1, 0, 0, 1, 0);
    tick(); chk("post_rst_lock", 16'h0040, 1, 0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsm_seq_ctrl.md
DSM_SEQ_CTRL -- requirements
Module: dsm_seq_ctrl

Interface
REQ-001 SHALL provide these ports, one clock and one asynchronous active-high reset:
- clk  in  1  modulator clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- en  in  1  global run enable
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready at a rising edge
- cfg_word  in  16  target modulator input word, unsigned
- cfg_step  in  16  ramp step per cycle, unsigned; 0 means jump
- mod_en  out  1  accumulator/noise-shaper run enable
- mod_clr  out  1  synchronous clear to accumulators and noise shaper
- mod_word  out  16  word driven into the MASH accumulator chain
- busy  out  1  high in any state other than IDLE and LOCK
- settled  out  1  mod_word equals accepted target and modulator running

Function
REQ-002 SHALL implement states IDLE, FLUSH, RAMP, LOCK, DRAIN, held in a registered state variable.
REQ-003 SHALL decode outputs from the state register only: mod_clr = FLUSH|DRAIN; mod_en = RAMP|LOCK; settled = LOCK; busy = FLUSH|RAMP|DRAIN; cfg_ready = en & (IDLE|LOCK).
REQ-004 SHALL, in IDLE, on an accepted cfg, capture cfg_word into target and cfg_step into step, then go to FLUSH.
REQ-005 SHALL hold FLUSH for exactly 3 cycles, counted by a 2-bit counter, to clear the 2 differentiator delays plus the output register; mod_word SHALL be forced to 0 in FLUSH; exit is to RAMP.
REQ-006 SHALL, at each rising edge in RAMP, compute next = mod_word + step when target > mod_word, or mod_word - step when target < mod_word.
REQ-007 SHALL clamp next to target whenever the step would reach or pass target, and when step == 0; no overshoot and no 16-bit wrap are permitted, so the compare uses 17-bit arithmetic.
REQ-008 SHALL load mod_word <= next, and go to LOCK on the same edge when next == target.
REQ-009 SHALL, when RAMP is entered with mod_word == target, go to LOCK on the first edge with mod_word unchanged.
REQ-010 SHALL, in LOCK, hold mod_word; an accepted cfg SHALL capture the new target/step and go directly to RAMP without FLUSH, ramping from the current mod_word.
REQ-011 SHALL ignore cfg_valid in FLUSH, RAMP and DRAIN (cfg_ready = 0) and SHALL NOT modify the captured target or step in those states.
REQ-012 SHALL, when en = 0 at a rising edge in FLUSH, RAMP or LOCK, go to DRAIN; this takes priority over any other transition, including a cfg handshake.
REQ-013 SHALL last 1 cycle in DRAIN: mod_word <= 0 on entry, then go to IDLE unconditionally.
REQ-014 SHALL, in IDLE with en = 0, make no transition and keep mod_word at 0.
REQ-015 SHALL keep target and step registers unchanged except on an accepted handshake.

Reset
REQ-016 SHALL, while rst = 1 and independent of clk, force: state = IDLE, FLUSH counter = 0, target = 0, step = 0, mod_word = 0. Decoded outputs SHALL follow: mod_en = 0, mod_clr = 0, settled = 0, busy = 0, cfg_ready = en.
REQ-017 SHALL abandon any ramp in progress when rst is asserted mid-operation; after release, the first transition SHALL be the normal IDLE behaviour.

Verification
REQ-018 SHALL be covered by these directed scenarios:
- en = 1; cfg 0x0100 / step 0x0040 from IDLE -> mod_clr = 1 for 3 cycles, then mod_word 0x0040, 0x0080, 0x00C0, 0x0100 on consecutive edges; settled = 1 from the 0x0100 edge; cfg_ready low throughout FLUSH and RAMP.
- Non-dividing step: cfg 0x0050 / step 0x0030 -> mod_word 0x0030 then 0x0050, never 0x0060.
- In LOCK at 0x0100, cfg 0x0000 / step 0x0080 -> no mod_clr pulse; mod_word 0x0080, 0x0000; settled drops for exactly 2 cycles.
- step = 0, cfg 0xFFF0 from LOCK at 0x0010 -> mod_word 0xFFF0 after one edge, then LOCK; repeat near 0xFFFF with step 0x0100 to confirm no wrap.
- en dropped mid-RAMP with cfg_valid = 1 -> DRAIN for 1 cycle (mod_clr = 1, mod_en = 0), mod_word = 0, then IDLE; cfg not captured.
- rst pulsed asynchronously between edges mid-RAMP -> all outputs at reset values immediately; normal sequence after release.
